mult_ctrl_16: RTL and testbench

Control unit for the Lab 5 16-bit shift-add multiplier. It sequences the accumulator register (A), multiplier register (B) and sign-extension flip-flop (X) through one clear step and N add/shift iterations, issuing a two's-complement subtract on the final iteration. The result is a signed 2N-bit product held in {A, B}. The block sits between the top-level switches/buttons and the datapath registers and adder, and owns no data bits itself.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_iter_cnt.sv | 34 +++
 rtl/mult_ctrl_16.sv | 93 +++++++++
 tb/tb_mult_ctrl_16.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    // Default operand width and iteration count
    localparam int MULT_N = 16;

    // Control sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter: sync clear, enable, terminal flag at N-1.
// Latency: count updates on the edge after clear/enable is sampled.
// Backpressure: none; the sequencer alone decides when to count.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_term
);

    logic [CW-1:0] r_count;

    // Iteration index: reset and clear both return to zero, clear wins over enable
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl_16.sv
// Shift-add multiplier sequencer: clear, N x (add|sub, shift), hold result.
// Latency: Done rises 2N+2 cycles after the edge that samples Run in IDLE.
// Backpressure: none; Run is a level handshake, HOLD waits for Run to drop.
module mult_ctrl_16
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Run,
    input  logic                 ClearA_LoadB,
    input  logic                 M,
    output logic                 Clr_Ld,
    output logic                 Clr_XA,
    output logic                 Add,
    output logic                 Sub,
    output logic                 Shift,
    output logic                 Busy,
    output logic                 Done,
    output logic [$clog2(N)-1:0] Count
);

    mult_state_t          r_state;
    mult_state_t          w_next;
    logic                 r_clr_xa;
    logic                 r_shift;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_cnt_clr;
    logic                 w_cnt_en;
    logic                 w_term;
    logic [$clog2(N)-1:0] w_count;

    mult_iter_cnt #(
        .N  (N),
        .CW ($clog2(N))
    ) u_iter_cnt (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_term  (w_term)
    );

    // Next-state selection; HOLD releases only once Run is seen low so a held Run cannot retrigger
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Run) w_next = CLR;
            CLR:     w_next = ADD;
            ADD:     w_next = SHIFT;
            SHIFT:   w_next = w_term ? HOLD : ADD;
            HOLD:    if (!Run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counter is zeroed while in CLR and advances on the SHIFT->ADD edge only
    assign w_cnt_clr = (r_state == CLR);
    assign w_cnt_en  = (r_state == SHIFT) && !w_term;

    // State register with state-decoded outputs registered from the next state
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_clr_xa <= 1'b0;
            r_shift  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_clr_xa <= (w_next == CLR);
            r_shift  <= (w_next == SHIFT);
            r_busy   <= (w_next == CLR) || (w_next == ADD) || (w_next == SHIFT);
            r_done   <= (w_next == HOLD);
        end
    end

    // Add/Sub follow M within the ADD cycle; the final iteration subtracts the sign-weighted bit
    assign Add    = (r_state == ADD) && M && !w_term;
    assign Sub    = (r_state == ADD) && M && w_term;
    // Run has priority over a load request, and loads are honoured only in IDLE
    assign Clr_Ld = (r_state == IDLE) && ClearA_LoadB && !Run;

    assign Clr_XA = r_clr_xa;
    assign Shift  = r_shift;
    assign Busy   = r_busy;
    assign Done   = r_done;
    assign Count  = w_count;

endmodule

// File: tb/tb_mult_ctrl_16.sv
// Bench for mult_ctrl_16: cycle schedule model plus behavioural A/B/X datapath.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: n/a.
module tb_mult_ctrl_16;

    localparam int N = 16;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Run;
    logic        ClearA_LoadB;
    logic        m_drv;
    logic        m_in;
    logic        Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;
    logic [3:0]  Count;

    // behavioural datapath
    logic        loop_mode;
    logic [15:0] sw;
    logic [15:0] dp_s;
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic        dp_x = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_add, n_sub, n_shift;

    always #5 Clk = ~Clk;

    assign m_in = loop_mode ? dp_b[0] : m_drv;

    mult_ctrl_16 #(.N(N)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (m_in),
        .Clr_Ld       (Clr_Ld),
        .Clr_XA       (Clr_XA),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done),
        .Count        (Count)
    );

    // Datapath registers reacting to the control strobes
    always @(posedge Clk) begin
        if (Clr_Ld) begin
            dp_a <= '0;
            dp_x <= 1'b0;
            dp_b <= sw;
        end else if (Clr_XA) begin
            dp_a <= '0;
            dp_x <= 1'b0;
        end else if (Add) begin
            {dp_x, dp_a} <= {dp_a[15], dp_a} + {dp_s[15], dp_s};
        end else if (Sub) begin
            {dp_x, dp_a} <= {dp_a[15], dp_a} - {dp_s[15], dp_s};
        end else if (Shift) begin
            {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[15:1]};
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clr_ld"}, int'(Clr_Ld), 0);
        chk({tag, "_clr_xa"}, int'(Clr_XA), 0);
        chk({tag, "_add"},    int'(Add),    0);
        chk({tag, "_sub"},    int'(Sub),    0);
        chk({tag, "_shift"},  int'(Shift),  0);
        chk({tag, "_busy"},   int'(Busy),   0);
        chk({tag, "_done"},   int'(Done),   0);
    endtask

    // Cycle k counts from the edge that sampled Run=1 in IDLE (k=1 is CLR)
    task automatic run_sched(input int kmax, input bit rnd_m);
        bit is_add, is_sh;
        int it;
        n_add = 0; n_sub = 0; n_shift = 0;
        for (int k = 1; k <= kmax; k++) begin
            if (rnd_m) m_drv = 1'($urandom_range(0, 1));
            #1;
            is_add = (k >= 2) && (k <= 2*N) && (k % 2 == 0);
            is_sh  = (k >= 3) && (k <= 2*N + 1) && (k % 2 == 1);
            it     = is_add ? (k - 2) / 2 : (k - 3) / 2;
            chk("sched_clr_xa", int'(Clr_XA), int'(k == 1));
            chk("sched_add",    int'(Add),    int'(is_add && m_in && it < N - 1));
            chk("sched_sub",    int'(Sub),    int'(is_add && m_in && it == N - 1));
            chk("sched_shift",  int'(Shift),  int'(is_sh));
            chk("sched_busy",   int'(Busy),   int'(k <= 2*N + 1));
            chk("sched_done",   int'(Done),   int'(k >= 2*N + 2));
            chk("sched_clr_ld", int'(Clr_Ld), 0);
            chk("sched_onehot", int'($countones({Clr_Ld, Clr_XA, Add, Sub, Shift}) <= 1), 1);
            if (is_add || is_sh) chk("sched_count", int'(Count), it);
            n_add   += int'(Add);
            n_sub   += int'(Sub);
            n_shift += int'(Shift);
            if (k < kmax) tick();
        end
    endtask

    task automatic start_mult();
        Run = 1'b1;
        #1;
        chk("start_clr_ld", int'(Clr_Ld), 0);
        tick();
    endtask

    // Done holds with Run high (load requests ignored), then IDLE one cycle after Run drops
    task automatic finish_hold();
        ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("hold_done",   int'(Done),   1);
            chk("hold_busy",   int'(Busy),   0);
            chk("hold_clr_ld", int'(Clr_Ld), 0);
            chk("hold_clr_xa", int'(Clr_XA), 0);
        end
        Run = 1'b0;
        #1;
        chk("hold_done_until_edge", int'(Done), 1);
        tick();
        #1;
        chk("idle_done",   int'(Done),   0);
        chk("idle_busy",   int'(Busy),   0);
        chk("idle_clr_ld", int'(Clr_Ld), 1);
        ClearA_LoadB = 1'b0;
        #1;
        chk("idle_clr_ld_off", int'(Clr_Ld), 0);
    endtask

    task automatic do_mult(input logic [15:0] s, input logic [15:0] b);
        int p;
        loop_mode    = 1'b1;
        sw           = b;
        dp_s         = s;
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        tick();
        #1;
        chk("load_clr_ld", int'(Clr_Ld), 1);
        ClearA_LoadB = 1'b0;
        start_mult();
        run_sched(2*N + 2, 1'b0);
        p = int'($signed(s)) * int'($signed(b));
        chk("product", int'({dp_a, dp_b}), p);
        finish_hold();
        loop_mode = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n      = 1'b0;
        Run          = 1'b1;
        ClearA_LoadB = 1'b0;
        m_drv        = 1'b1;
        loop_mode    = 1'b0;
        sw           = '0;
        dp_s         = '0;

        // reset with Run high
        tick();
        #1;
        chk_all_zero("rst");
        chk("rst_count", int'(Count), 0);

        // release: Run still high starts a multiply; M tied 1
        Reset_n = 1'b1;
        tick();
        run_sched(2*N + 2, 1'b0);
        chk("m1_adds",   n_add,   N - 1);
        chk("m1_subs",   n_sub,   1);
        chk("m1_shifts", n_shift, N);
        finish_hold();

        // load request alone, then load request together with Run; M tied 0
        ClearA_LoadB = 1'b1;
        tick();
        #1;
        chk("load_clr_ld", int'(Clr_Ld), 1);
        chk("load_clr_xa", int'(Clr_XA), 0);
        chk("load_shift",  int'(Shift),  0);
        chk("load_busy",   int'(Busy),   0);
        m_drv = 1'b0;
        start_mult();
        run_sched(2*N + 2, 1'b0);
        chk("m0_adds",   n_add,   0);
        chk("m0_subs",   n_sub,   0);
        chk("m0_shifts", n_shift, N);
        finish_hold();

        // reset during the ADD of iteration 7
        m_drv = 1'b1;
        start_mult();
        run_sched(2 + 2*7, 1'b0);
        Reset_n = 1'b0;
        tick();
        #1;
        chk_all_zero("midrst");
        chk("midrst_count", int'(Count), 0);
        Run     = 1'b0;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk_all_zero("post_rst");
        end

        // random M every cycle
        for (int r = 0; r < 2; r++) begin
            start_mult();
            run_sched(2*N + 2, 1'b1);
            chk("rnd_shifts", n_shift, N);
            finish_hold();
        end

        // closed loop products
        do_mult(16'h0007, 16'hFFFD);
        do_mult(16'h8000, 16'h8000);
        do_mult(16'hFFFF, 16'h0001);
        for (int r = 0; r < 5; r++) begin
            do_mult(16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
